// File: rtl/common_types.sv
// common_types -- shared type definitions for the 6502 front end.
//
// Contents:
//   data_t    8-bit data / opcode byte
//   addr_t    16-bit address
//   opc_t     the 56 official NMOS 6502 mnemonics
//   addmod_t  the 13 NMOS 6502 addressing modes
//   NUM_OFFICIAL_OPCODES  number of documented opcode bytes (151)
package common_types;

   typedef logic [7:0]  data_t;
   typedef logic [15:0] addr_t;

   typedef enum logic [5:0] {
      ADC, AND, ASL, BCC, BCS, BEQ, BIT, BMI,
      BNE, BPL, BRK, BVC, BVS, CLC, CLD, CLI,
      CLV, CMP, CPX, CPY, DEC, DEX, DEY, EOR,
      INC, INX, INY, JMP, JSR, LDA, LDX, LDY,
      LSR, NOP, ORA, PHA, PHP, PLA, PLP, ROL,
      ROR, RTI, RTS, SBC, SEC, SED, SEI, STA,
      STX, STY, TAX, TAY, TSX, TXA, TXS, TYA
   } opc_t;

   typedef enum logic [3:0] {
      IMP, ACC, IMM, ZP, ZPX, ZPY, ABS, ABSX, ABSY, IND, INDX, INDY, REL
   } addmod_t;

   localparam int NUM_OFFICIAL_OPCODES = 151;

endpackage : common_types

// File: rtl/decode.sv
// decode -- NMOS 6502 opcode decoder.
//
// Maps an opcode byte to its mnemonic and addressing mode. Any byte that is
// not one of the 151 documented NMOS opcodes decodes as NOP/IMP with
// illegal raised.
//
// Configuration macro: DECODE_REG_OUT_EN
//   undefined (default): outputs are purely combinational from instr; clk and
//                        reset are ignored. The CPU samples the result in the
//                        same fetch cycle, so no register is wanted.
//   defined:             outputs are registered on rising clk (1-cycle
//                        latency); synchronous active-high reset forces
//                        NOP/IMP/illegal=0.
//
// Ports:
//   clk      in   1         clock (used only with DECODE_REG_OUT_EN)
//   reset    in   1         synchronous active-high reset (registered build)
//   instr    in   data_t    opcode byte to decode
//   opcode   out  opc_t     decoded mnemonic
//   mode     out  addmod_t  decoded addressing mode
//   illegal  out  1         high when instr is not an official opcode
module decode
   import common_types::*;
(
   input  logic    clk,
   input  logic    reset,
   input  data_t   instr,
   output opc_t    opcode,
   output addmod_t mode,
   output logic    illegal
);

   opc_t    w_opcode;
   addmod_t w_mode;
   logic    w_illegal;

   logic [2:0] w_aaa;
   logic [2:0] w_bbb;
   logic       w_xy_index;  // group-2 STX/LDX index with Y instead of X

   assign w_aaa      = instr[7:5];
   assign w_bbb      = instr[4:2];
   assign w_xy_index = (w_aaa == 3'd4) || (w_aaa == 3'd5);

   // Combinational decode. Defaults describe an unofficial byte; every
   // documented entry overrides all three outputs.
   always_comb begin
      w_opcode  = NOP;
      w_mode    = IMP;
      w_illegal = 1'b1;

      case (instr[1:0])
         // ---------------- group 1: ALU ops on the accumulator ----------
         2'b01: begin
            case (w_aaa)
               3'd0:    w_opcode = ORA;
               3'd1:    w_opcode = AND;
               3'd2:    w_opcode = EOR;
               3'd3:    w_opcode = ADC;
               3'd4:    w_opcode = STA;
               3'd5:    w_opcode = LDA;
               3'd6:    w_opcode = CMP;
               default: w_opcode = SBC;
            endcase
            case (w_bbb)
               3'd0:    w_mode = INDX;
               3'd1:    w_mode = ZP;
               3'd2:    w_mode = IMM;
               3'd3:    w_mode = ABS;
               3'd4:    w_mode = INDY;
               3'd5:    w_mode = ZPX;
               3'd6:    w_mode = ABSY;
               default: w_mode = ABSX;
            endcase
            w_illegal = 1'b0;
            // Storing to an immediate is meaningless: 0x89 is undocumented.
            if (instr == 8'h89) begin
               w_opcode  = NOP;
               w_mode    = IMP;
               w_illegal = 1'b1;
            end
         end

         // ---------------- group 2: shifts, X register, inc/dec --------
         2'b10: begin
            case (w_aaa)
               3'd0:    w_opcode = ASL;
               3'd1:    w_opcode = ROL;
               3'd2:    w_opcode = LSR;
               3'd3:    w_opcode = ROR;
               3'd4:    w_opcode = STX;
               3'd5:    w_opcode = LDX;
               3'd6:    w_opcode = DEC;
               default: w_opcode = INC;
            endcase
            w_illegal = 1'b0;
            case (w_bbb)
               3'd0: begin
                  // Only LDX #imm lives in this column.
                  if (instr == 8'hA2) begin
                     w_mode = IMM;
                  end else begin
                     w_illegal = 1'b1;
                  end
               end
               3'd1: w_mode = ZP;
               3'd2: begin
                  // Upper half of this column holds single-byte X-register ops.
                  case (instr)
                     8'h8A:   w_opcode = TXA;
                     8'hAA:   w_opcode = TAX;
                     8'hCA:   w_opcode = DEX;
                     8'hEA:   w_opcode = NOP;
                     default: w_mode   = ACC;
                  endcase
               end
               3'd3: w_mode = ABS;
               3'd5: w_mode = w_xy_index ? ZPY : ZPX;
               3'd6: begin
                  case (instr)
                     8'h9A:   w_opcode  = TXS;
                     8'hBA:   w_opcode  = TSX;
                     default: w_illegal = 1'b1;
                  endcase
               end
               3'd7: begin
                  // STX has no absolute-indexed form.
                  if (instr == 8'h9E) begin
                     w_illegal = 1'b1;
                  end else begin
                     w_mode = w_xy_index ? ABSY : ABSX;
                  end
               end
               default: w_illegal = 1'b1;  // bbb=100 column is empty
            endcase
            if (w_illegal) begin
               w_opcode = NOP;
               w_mode   = IMP;
            end
         end

         // ---------------- group 0: control flow, flags, Y register ----
         2'b00: begin
            w_illegal = 1'b0;
            case (instr)
               8'h10: begin w_opcode = BPL; w_mode = REL;  end
               8'h30: begin w_opcode = BMI; w_mode = REL;  end
               8'h50: begin w_opcode = BVC; w_mode = REL;  end
               8'h70: begin w_opcode = BVS; w_mode = REL;  end
               8'h90: begin w_opcode = BCC; w_mode = REL;  end
               8'hB0: begin w_opcode = BCS; w_mode = REL;  end
               8'hD0: begin w_opcode = BNE; w_mode = REL;  end
               8'hF0: begin w_opcode = BEQ; w_mode = REL;  end
               8'h00: begin w_opcode = BRK; w_mode = IMP;  end
               8'h40: begin w_opcode = RTI; w_mode = IMP;  end
               8'h60: begin w_opcode = RTS; w_mode = IMP;  end
               8'h08: begin w_opcode = PHP; w_mode = IMP;  end
               8'h28: begin w_opcode = PLP; w_mode = IMP;  end
               8'h48: begin w_opcode = PHA; w_mode = IMP;  end
               8'h68: begin w_opcode = PLA; w_mode = IMP;  end
               8'h88: begin w_opcode = DEY; w_mode = IMP;  end
               8'hA8: begin w_opcode = TAY; w_mode = IMP;  end
               8'hC8: begin w_opcode = INY; w_mode = IMP;  end
               8'hE8: begin w_opcode = INX; w_mode = IMP;  end
               8'h18: begin w_opcode = CLC; w_mode = IMP;  end
               8'h38: begin w_opcode = SEC; w_mode = IMP;  end
               8'h58: begin w_opcode = CLI; w_mode = IMP;  end
               8'h78: begin w_opcode = SEI; w_mode = IMP;  end
               8'h98: begin w_opcode = TYA; w_mode = IMP;  end
               8'hB8: begin w_opcode = CLV; w_mode = IMP;  end
               8'hD8: begin w_opcode = CLD; w_mode = IMP;  end
               8'hF8: begin w_opcode = SED; w_mode = IMP;  end
               8'h20: begin w_opcode = JSR; w_mode = ABS;  end
               8'h4C: begin w_opcode = JMP; w_mode = ABS;  end
               8'h6C: begin w_opcode = JMP; w_mode = IND;  end
               8'h24: begin w_opcode = BIT; w_mode = ZP;   end
               8'h2C: begin w_opcode = BIT; w_mode = ABS;  end
               8'h84: begin w_opcode = STY; w_mode = ZP;   end
               8'h8C: begin w_opcode = STY; w_mode = ABS;  end
               8'h94: begin w_opcode = STY; w_mode = ZPX;  end
               8'hA0: begin w_opcode = LDY; w_mode = IMM;  end
               8'hA4: begin w_opcode = LDY; w_mode = ZP;   end
               8'hAC: begin w_opcode = LDY; w_mode = ABS;  end
               8'hB4: begin w_opcode = LDY; w_mode = ZPX;  end
               8'hBC: begin w_opcode = LDY; w_mode = ABSX; end
               8'hC0: begin w_opcode = CPY; w_mode = IMM;  end
               8'hC4: begin w_opcode = CPY; w_mode = ZP;   end
               8'hCC: begin w_opcode = CPY; w_mode = ABS;  end
               8'hE0: begin w_opcode = CPX; w_mode = IMM;  end
               8'hE4: begin w_opcode = CPX; w_mode = ZP;   end
               8'hEC: begin w_opcode = CPX; w_mode = ABS;  end
               default: begin
                  w_opcode  = NOP;
                  w_mode    = IMP;
                  w_illegal = 1'b1;
               end
            endcase
         end

         // ---------------- group 3: nothing documented -----------------
         default: begin
            w_opcode  = NOP;
            w_mode    = IMP;
            w_illegal = 1'b1;
         end
      endcase
   end

`ifdef DECODE_REG_OUT_EN
   opc_t    r_opcode;
   addmod_t r_mode;
   logic    r_illegal;

   // Reset wins over whatever instr presents at the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_opcode  <= NOP;
         r_mode    <= IMP;
         r_illegal <= 1'b0;
      end else begin
         r_opcode  <= w_opcode;
         r_mode    <= w_mode;
         r_illegal <= w_illegal;
      end
   end

   assign opcode  = r_opcode;
   assign mode    = r_mode;
   assign illegal = r_illegal;
`else
   // Clock and reset are kept on the port list so both builds share one
   // interface; here they are intentionally unused.
   logic w_unused_clk_reset;
   assign w_unused_clk_reset = clk ^ reset;

   assign opcode  = w_opcode;
   assign mode    = w_mode;
   assign illegal = w_illegal;
`endif

endmodule : decode

// File: tb/tb_decode.sv
// tb_decode -- directed self-checking bench for decode. Works in both the
// combinational build and the DECODE_REG_OUT_EN build.
module tb_decode;
  import common_types::*;

  logic    clk;
  logic    reset;
  data_t   instr;
  opc_t    opcode;
  addmod_t mode;
  logic    illegal;

  int n_checks;
  int n_pass;

  typedef struct packed {
    logic [7:0] b;
    opc_t       o;
    addmod_t    m;
    logic       il;
  } vec_t;

  vec_t vecs[$];

  decode dut (
    .clk     (clk),
    .reset   (reset),
    .instr   (instr),
    .opcode  (opcode),
    .mode    (mode),
    .illegal (illegal)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a byte and wait until its decode is visible on the outputs.
  task automatic apply(input logic [7:0] b);
    instr = b;
`ifdef DECODE_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic check_vec(input vec_t v);
    apply(v.b);
    check($sformatf("op_%02h", v.b),  32'(opcode),  32'(v.o));
    check($sformatf("md_%02h", v.b),  32'(mode),    32'(v.m));
    check($sformatf("il_%02h", v.b),  32'(illegal), 32'(v.il));
  endtask

  initial begin
    int legal_cnt;
    int x_cnt;
    int g3_ill_cnt;

    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    instr    = 8'hEA;

    vecs.push_back('{8'hA2, LDX, IMM,  1'b0});
    vecs.push_back('{8'hA6, LDX, ZP,   1'b0});
    vecs.push_back('{8'hB6, LDX, ZPY,  1'b0});
    vecs.push_back('{8'hBE, LDX, ABSY, 1'b0});
    vecs.push_back('{8'hE8, INX, IMP,  1'b0});
    vecs.push_back('{8'h6C, JMP, IND,  1'b0});
    vecs.push_back('{8'h0A, ASL, ACC,  1'b0});
    vecs.push_back('{8'hB1, LDA, INDY, 1'b0});
    vecs.push_back('{8'h02, NOP, IMP,  1'b1});
    vecs.push_back('{8'h89, NOP, IMP,  1'b1});
    vecs.push_back('{8'hFF, NOP, IMP,  1'b1});
    vecs.push_back('{8'hEA, NOP, IMP,  1'b0});
    vecs.push_back('{8'h00, BRK, IMP,  1'b0});
    vecs.push_back('{8'h20, JSR, ABS,  1'b0});
    vecs.push_back('{8'h4C, JMP, ABS,  1'b0});
    vecs.push_back('{8'h96, STX, ZPY,  1'b0});
    vecs.push_back('{8'h8E, STX, ABS,  1'b0});
    vecs.push_back('{8'h9E, NOP, IMP,  1'b1});
    vecs.push_back('{8'h81, STA, INDX, 1'b0});
    vecs.push_back('{8'h7D, ADC, ABSX, 1'b0});
    vecs.push_back('{8'h19, ORA, ABSY, 1'b0});
    vecs.push_back('{8'hC9, CMP, IMM,  1'b0});
    vecs.push_back('{8'hE1, SBC, INDX, 1'b0});
    vecs.push_back('{8'h55, EOR, ZPX,  1'b0});
    vecs.push_back('{8'hBC, LDY, ABSX, 1'b0});
    vecs.push_back('{8'h94, STY, ZPX,  1'b0});
    vecs.push_back('{8'hF0, BEQ, REL,  1'b0});
    vecs.push_back('{8'h9A, TXS, IMP,  1'b0});
    vecs.push_back('{8'hBA, TSX, IMP,  1'b0});
    vecs.push_back('{8'hCA, DEX, IMP,  1'b0});
    vecs.push_back('{8'hDE, DEC, ABSX, 1'b0});
    vecs.push_back('{8'h76, ROR, ZPX,  1'b0});
    vecs.push_back('{8'h4A, LSR, ACC,  1'b0});
    vecs.push_back('{8'h2C, BIT, ABS,  1'b0});
    vecs.push_back('{8'hEC, CPX, ABS,  1'b0});
    vecs.push_back('{8'hFA, NOP, IMP,  1'b1});
    vecs.push_back('{8'h34, NOP, IMP,  1'b1});
    vecs.push_back('{8'h12, NOP, IMP,  1'b1});
    vecs.push_back('{8'h80, NOP, IMP,  1'b1});

`ifdef DECODE_REG_OUT_EN
    // Reset phase: outputs forced to NOP/IMP/0 even with a decodable byte.
    reset = 1'b1;
    instr = 8'hA9;
    @(posedge clk); #1;
    check("rst1_op", 32'(opcode),  32'(NOP));
    check("rst1_md", 32'(mode),    32'(IMP));
    check("rst1_il", 32'(illegal), 32'd0);
    @(posedge clk); #1;
    check("rst2_op", 32'(opcode),  32'(NOP));
    check("rst2_md", 32'(mode),    32'(IMP));
    check("rst2_il", 32'(illegal), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rel_op", 32'(opcode), 32'(LDA));
    check("rel_md", 32'(mode),   32'(IMM));
    check("rel_il", 32'(illegal), 32'd0);
    // Mid-stream reset with a simultaneous change to an illegal byte.
    apply(8'hE8);
    check("pre_op", 32'(opcode), 32'(INX));
    reset = 1'b1;
    instr = 8'hFF;
    @(posedge clk); #1;
    check("mid_op", 32'(opcode),  32'(NOP));
    check("mid_md", 32'(mode),    32'(IMP));
    check("mid_il", 32'(illegal), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_il", 32'(illegal), 32'd1);
`else
    // Reset has no effect on the combinational decoder.
    reset = 1'b1;
    apply(8'hA9);
    check("norst_op", 32'(opcode), 32'(LDA));
    check("norst_md", 32'(mode),   32'(IMM));
    reset = 1'b0;
`endif

    foreach (vecs[i]) check_vec(vecs[i]);

    // Exhaustive sweep.
    legal_cnt  = 0;
    x_cnt      = 0;
    g3_ill_cnt = 0;
    for (int b = 0; b < 256; b++) begin
      apply(8'(b));
      if ($isunknown({opcode, mode, illegal})) x_cnt++;
      if (illegal === 1'b0) legal_cnt++;
      if ((b % 4) == 3 && illegal === 1'b1 && opcode === NOP && mode === IMP) g3_ill_cnt++;
    end
    check("sweep_legal", 32'(legal_cnt),  32'd151);
    check("sweep_x",     32'(x_cnt),      32'd0);
    check("sweep_g3",    32'(g3_ill_cnt), 32'd64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_decode
